monster_move: RTL



---
 rtl/monster_move.sv | 136 +++++++++++++
 1 files changed

// File: rtl/monster_move.sv
// Frame-paced position generator for the invaders monster block: horizontal sweep,
// step down at each screen edge, and a landed flag once the bottom reaches the landing line.
module monster_move #(
    parameter int INITIAL_X       = 64,
    parameter int INITIAL_Y       = 32,
    parameter int OBJECT_WIDTH_X  = 512,
    parameter int OBJECT_HEIGHT_Y = 256,
    parameter int SCREEN_LEFT     = 0,
    parameter int SCREEN_RIGHT    = 640,
    parameter int X_STEP          = 8,
    parameter int STEP_DOWN       = 16,
    parameter int LANDING_Y       = 400,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               restart,
    input  logic [1:0]         speedLevel,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               movingRight,
    output logic               landed
);

    // state  | meaning
    // IDLE   | parked at initial position, waiting for first enabled frame
    // MOVE_R | sweeping right by X_STEP per move event
    // MOVE_L | sweeping left by X_STEP per move event
    // DOWN_R | clamped at right edge, next move event steps down
    // DOWN_L | clamped at left edge, next move event steps down
    // LANDED | bottom reached landing line, everything held
    typedef enum logic [2:0] {IDLE, MOVE_R, MOVE_L, DOWN_R, DOWN_L, LANDED} state_t;

    localparam int CW = 16;
    localparam logic signed [12:0] P_IX  = 13'(INITIAL_X);
    localparam logic signed [12:0] P_IY  = 13'(INITIAL_Y);
    localparam logic signed [12:0] P_W   = 13'(OBJECT_WIDTH_X);
    localparam logic signed [12:0] P_H   = 13'(OBJECT_HEIGHT_Y);
    localparam logic signed [12:0] P_SL  = 13'(SCREEN_LEFT);
    localparam logic signed [12:0] P_SR  = 13'(SCREEN_RIGHT);
    localparam logic signed [12:0] P_XS  = 13'(X_STEP);
    localparam logic signed [12:0] P_DN  = 13'(STEP_DOWN);
    localparam logic signed [12:0] P_LY  = 13'(LANDING_Y);
    localparam logic [CW-1:0]      P_FPS = CW'(FRAMES_PER_STEP);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic signed [10:0]    r_x;
    logic signed [10:0]    r_y;
    logic                  r_right;
    logic                  r_landed;

    logic [CW-1:0]         w_shift;
    logic [CW-1:0]         w_div;
    logic                  w_event;
    logic signed [12:0]    w_xe;
    logic signed [12:0]    w_ye;
    logic signed [12:0]    w_y_new;

    assign w_shift = P_FPS >> speedLevel;
    assign w_div   = (w_shift == '0) ? CW'(1) : w_shift;
    // >= rather than == so a speed-up with a large pending count fires on the next pulse
    assign w_event = (r_cnt >= (w_div - CW'(1)));
    assign w_xe    = r_x;
    assign w_ye    = r_y;
    assign w_y_new = w_ye + P_DN;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_x      <= 11'(P_IX);
            r_y      <= 11'(P_IY);
            r_right  <= 1'b1;
            r_landed <= 1'b0;
        end else if (restart) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_x      <= 11'(P_IX);
            r_y      <= 11'(P_IY);
            r_right  <= 1'b1;
            r_landed <= 1'b0;
        end else if (startOfFrame && enable) begin
            case (r_state)
                IDLE: r_state <= MOVE_R;
                MOVE_R, MOVE_L, DOWN_R, DOWN_L: begin
                    if (!w_event) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt <= '0;
                        case (r_state)
                            MOVE_R: begin
                                if (w_xe + P_W + P_XS > P_SR) begin
                                    r_x     <= 11'(P_SR - P_W);
                                    r_state <= DOWN_R;
                                end else begin
                                    r_x <= 11'(w_xe + P_XS);
                                end
                            end
                            MOVE_L: begin
                                if (w_xe - P_XS < P_SL) begin
                                    r_x     <= 11'(P_SL);
                                    r_state <= DOWN_L;
                                end else begin
                                    r_x <= 11'(w_xe - P_XS);
                                end
                            end
                            default: begin
                                r_y <= 11'(w_y_new);
                                if (w_y_new + P_H >= P_LY) begin
                                    r_state  <= LANDED;
                                    r_landed <= 1'b1;
                                end else if (r_state == DOWN_R) begin
                                    r_state <= MOVE_L;
                                    r_right <= 1'b0;
                                end else begin
                                    r_state <= MOVE_R;
                                    r_right <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign topLeftX    = r_x;
    assign topLeftY    = r_y;
    assign movingRight = r_right;
    assign landed      = r_landed;

endmodule
